// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues instruction-bus requests, buffers {pc, instr} for decode, squashes stale fetches.
// Define FETCH_ADEL_EN to trap misaligned fetch PCs instead of silently aligning the bus address.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_pc_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_instr_q;
    logic        redir_pend_q;
    logic        out_valid_q;
    logic        out_adel_q;
    logic        adel_lock_q;

    logic        misalign;
    logic        req_vis;
    logic        buf_free;
    logic [31:0] pc_inc_d;

`ifdef FETCH_ADEL_EN
    assign misalign  = (pc_q[1:0] != 2'b00);
    assign ireq_addr = pc_q;
`else
    assign misalign  = 1'b0;
    assign ireq_addr = {pc_q[31:2], 2'b00};
`endif

    assign pc_inc_d   = pc_q + 32'd4;
    assign req_vis    = (state_q == S_REQ) && !misalign;
    assign ireq_valid = resetn && req_vis;
    assign buf_free   = !out_valid_q || out_ready;

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_instr  = out_instr_q;
    assign out_adel   = out_adel_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            redir_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'h0;
            out_instr_q  <= 32'h0;
            out_adel_q   <= 1'b0;
            adel_lock_q  <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (redirect_valid) begin
                out_valid_q <= 1'b0;
                adel_lock_q <= 1'b0;
                case (state_q)
                    S_REQ: begin
                        // An offered but unaccepted request must keep its address; park the target.
                        if (req_vis && !ireq_addr_ok) begin
                            redir_pend_q <= 1'b1;
                            pend_pc_q    <= redirect_pc;
                        end else begin
                            pc_q         <= redirect_pc;
                            redir_pend_q <= 1'b0;
                            if (req_vis) begin
                                state_q <= S_DROP;
                            end
                        end
                    end
                    S_WAIT: begin
                        pc_q    <= redirect_pc;
                        state_q <= iresp_data_ok ? S_REQ : S_DROP;
                    end
                    S_HOLD: begin
                        pc_q    <= redirect_pc;
                        state_q <= S_REQ;
                    end
                    default: begin
                        pc_q <= redirect_pc;
                        if (iresp_data_ok) begin
                            state_q <= S_REQ;
                        end
                    end
                endcase
            end else begin
                case (state_q)
                    S_REQ: begin
                        if (misalign) begin
                            if (buf_free) begin
                                out_valid_q <= 1'b1;
                                out_pc_q    <= pc_q;
                                out_instr_q <= 32'h0;
                                out_adel_q  <= 1'b1;
                                adel_lock_q <= 1'b1;
                                state_q     <= S_HOLD;
                            end
                        end else if (ireq_addr_ok) begin
                            if (redir_pend_q) begin
                                pc_q         <= pend_pc_q;
                                redir_pend_q <= 1'b0;
                                state_q      <= S_DROP;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (iresp_data_ok) begin
                            out_valid_q <= 1'b1;
                            out_pc_q    <= pc_q;
                            out_instr_q <= iresp_data;
                            out_adel_q  <= 1'b0;
                            pc_q        <= pc_inc_d;
                            state_q     <= out_ready ? S_REQ : S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        // A trapped misaligned PC stays parked until execute redirects.
                        if (out_valid_q && out_ready && !adel_lock_q) begin
                            state_q <= S_REQ;
                        end
                    end
                    default: begin
                        if (iresp_data_ok) begin
                            state_q <= S_REQ;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: bus responder, expected-output queue and decoupled output monitor.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_addr_ok   (ireq_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_adel       (out_adel)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          acc_total = 0;
    int          acc_limit = 0;
    int          acc_cnt = 0;
    int          lat = 0;
    logic [31:0] acc_addr = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic adel);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.adel  = adel;
        exp_q.push_back(e);
    endtask

    // Bus responder: one outstanding request, data returns 1+lat cycles after acceptance, word = ~addr.
    always begin
        @(negedge clk);
        #2;
        if (acc_cnt == 1) begin
            iresp_data_ok = 1'b1;
            iresp_data    = ~acc_addr;
        end else begin
            iresp_data_ok = 1'b0;
            iresp_data    = 32'h0;
        end
        if (acc_cnt > 0) acc_cnt--;
        if (ireq_valid && acc_cnt == 0 && acc_total < acc_limit) begin
            ireq_addr_ok = 1'b1;
            acc_addr     = ireq_addr;
            acc_cnt      = 1 + lat;
            acc_total++;
        end else begin
            ireq_addr_ok = 1'b0;
        end
    end

    // Monitor: every handshake on the decode side must match the head of the expected queue.
    always begin
        @(negedge clk);
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h instr %h, required no output", out_pc, out_instr);
            end else begin
                mon_e = exp_q.pop_front();
                check32("out_pc", out_pc, mon_e.pc);
                check32("out_instr", out_instr, mon_e.instr);
                check32("out_adel", {31'b0, out_adel}, {31'b0, mon_e.adel});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        acc_limit      = acc_total;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        check32("leftover_expected", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check32("rst_ireq_valid", {31'b0, ireq_valid}, 32'd0);
        check32("rst_out_pc", out_pc, 32'h0);
        check32("rst_out_instr", out_instr, 32'h0);
        check32("rst_out_adel", {31'b0, out_adel}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        lat    = 0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d entries pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (ireq_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check32({name, "_req_seen"}, {31'b0, seen}, 32'd1);
        if (seen) check32({name, "_addr"}, ireq_addr, addr);
    endtask

    task automatic wait_acc(input int start);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (acc_total != start) begin
                seen = 1'b1;
                break;
            end
        end
        check32("accept_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_out_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check32("out_valid_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int start;
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ireq_addr_ok   = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0;
        out_ready      = 1'b0;

        // Streaming fetch from the reset vector.
        do_reset();
        @(negedge clk);
        out_ready = 1'b1;
        push(32'hbfc00000, 32'h403fffff, 1'b0);
        push(32'hbfc00004, 32'h403ffffb, 1'b0);
        push(32'hbfc00008, 32'h403ffff7, 1'b0);
        acc_limit = acc_total + 3;
        drain("stream");
        wait_req("stream_next", 32'hbfc0000c);

        // Decode stall holds the buffer and suppresses requests.
        do_reset();
        @(negedge clk);
        push(32'hbfc00000, 32'h403fffff, 1'b0);
        acc_limit = acc_total + 1;
        wait_out_valid();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check32("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check32("hold_out_pc", out_pc, 32'hbfc00000);
            check32("hold_ireq_valid", {31'b0, ireq_valid}, 32'd0);
        end
        @(negedge clk);
        push(32'hbfc00004, 32'h403ffffb, 1'b0);
        acc_limit = acc_total + 1;
        out_ready = 1'b1;
        wait_req("hold_release", 32'hbfc00004);
        drain("hold");

        // Request not accepted for three cycles keeps its address.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check32("stall_ireq_valid", {31'b0, ireq_valid}, 32'd1);
            check32("stall_ireq_addr", ireq_addr, 32'hbfc00000);
        end
        @(negedge clk);
        out_ready = 1'b1;
        push(32'hbfc00000, 32'h403fffff, 1'b0);
        acc_limit = acc_total + 1;
        drain("stall");

        // Redirect while waiting, response still outstanding.
        do_reset();
        @(negedge clk);
        out_ready = 1'b1;
        lat       = 2;
        start     = acc_total;
        acc_limit = acc_total + 1;
        wait_acc(start);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80001000;
        @(negedge clk);
        redirect_valid = 1'b0;
        push(32'h80001000, 32'h7fffefff, 1'b0);
        acc_limit = acc_total + 1;
        wait_req("wait_redir", 32'h80001000);
        drain("wait_redir");

        // Redirect in the same cycle as the response.
        do_reset();
        @(negedge clk);
        out_ready = 1'b1;
        lat       = 1;
        start     = acc_total;
        acc_limit = acc_total + 1;
        wait_acc(start);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80003000;
        @(negedge clk);
        redirect_valid = 1'b0;
        push(32'h80003000, 32'h7fffcfff, 1'b0);
        acc_limit = acc_total + 1;
        #1;
        check32("samecyc_ireq_valid", {31'b0, ireq_valid}, 32'd1);
        check32("samecyc_ireq_addr", ireq_addr, 32'h80003000);
        drain("samecyc");

        // Redirect against an unaccepted request, accepted two cycles later.
        do_reset();
        @(negedge clk);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80002000;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check32("pend_addr_c1", ireq_addr, 32'hbfc00000);
        check32("pend_valid_c1", {31'b0, ireq_valid}, 32'd1);
        @(negedge clk);
        #1;
        check32("pend_addr_c2", ireq_addr, 32'hbfc00000);
        @(negedge clk);
        push(32'h80002000, 32'h7fffdfff, 1'b0);
        acc_limit = acc_total + 2;
        wait_req("pend_drop", 32'h80002000);
        drain("pend");

        // Back-to-back redirects (last wins) and PC wrap past 2^32.
        do_reset();
        @(negedge clk);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h12345678;
        @(negedge clk);
        redirect_pc    = 32'hfffffffc;
        @(negedge clk);
        redirect_valid = 1'b0;
        push(32'hfffffffc, 32'h00000003, 1'b0);
        push(32'h00000000, 32'hffffffff, 1'b0);
        acc_limit = acc_total + 3;
        drain("wrap");
        wait_req("wrap_next", 32'h00000004);

`ifdef FETCH_ADEL_EN
        // Misaligned target is trapped without any bus request.
        do_reset();
        @(negedge clk);
        acc_limit = acc_total + 1;
        wait_out_valid();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000002;
        @(negedge clk);
        redirect_valid = 1'b0;
        push(32'h80000002, 32'h00000000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check32("adel_ireq_valid", {31'b0, ireq_valid}, 32'd0);
            check32("adel_out_valid", {31'b0, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check32("adel_lock_ireq_valid", {31'b0, ireq_valid}, 32'd0);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80004000;
        push(32'h80004000, 32'h7fffbfff, 1'b0);
        acc_limit = acc_total + 1;
        @(negedge clk);
        redirect_valid = 1'b0;
        drain("adel");
`else
        // Misaligned target: bus address is aligned, delivered PC is the verbatim target.
        do_reset();
        @(negedge clk);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000002;
        @(negedge clk);
        redirect_valid = 1'b0;
        push(32'h80000002, 32'h7fffffff, 1'b0);
        acc_limit = acc_total + 2;
        drain("misalign");
        wait_req("misalign_next", 32'h80000004);
`endif

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
